// File: rtl/decoder3_8_scan_if.sv
// Handshake and output bundle for the registered 3-to-8 scan decoder.
// The slave side is the decoder; the master side is the controlling logic.
interface decoder3_8_scan_if;
  logic       E;
  logic [2:0] A;
  logic       in_valid;
  logic       in_ready;
  logic       scan_start;
  logic [7:0] Y;
  logic [2:0] code_o;
  logic       busy;
  logic       scan_done;

  modport slave (
    input  E, A, in_valid, scan_start,
    output in_ready, Y, code_o, busy, scan_done
  );

  modport master (
    output E, A, in_valid, scan_start,
    input  in_ready, Y, code_o, busy, scan_done
  );
endinterface

// File: rtl/decoder3_8_scan.sv
// Registered 3-to-8 decoder with active-low outputs: holds a directly decoded
// line for HOLD cycles, or scans lines 0..7 for DWELL cycles each.
module decoder3_8_scan #(
  parameter int unsigned HOLD  = 4,
  parameter int unsigned DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  decoder3_8_scan_if.slave    bus
);

  localparam int unsigned MAXC = (HOLD > DWELL) ? HOLD : DWELL;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_y;
  logic [2:0]      r_code;
  logic            r_busy;
  logic            r_done;

  state_t          w_state_next;
  logic [CW-1:0]   w_cnt_next;
  logic [7:0]      w_y_next;
  logic [2:0]      w_code_next;
  logic            w_busy_next;
  logic            w_done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_y     <= 8'hFF;
      r_code  <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_y     <= w_y_next;
      r_code  <= w_code_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_y_next     = r_y;
    w_code_next  = r_code;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;

    if (bus.E) begin
      // Disable aborts whatever is in flight and never reports a scan as done.
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
      w_y_next     = 8'hFF;
      w_code_next  = 3'd0;
      w_busy_next  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            w_state_next = ST_HOLD;
            w_cnt_next   = CW'(HOLD - 1);
            w_y_next     = ~(8'b1 << bus.A);
            w_code_next  = bus.A;
            w_busy_next  = 1'b1;
          end else if (bus.scan_start) begin
            w_state_next = ST_SCAN;
            w_cnt_next   = CW'(DWELL - 1);
            w_y_next     = 8'hFE;
            w_code_next  = 3'd0;
            w_busy_next  = 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_cnt == '0) begin
            w_state_next = ST_IDLE;
            w_y_next     = 8'hFF;
            w_code_next  = 3'd0;
            w_busy_next  = 1'b0;
          end else begin
            w_cnt_next = r_cnt - CW'(1);
          end
        end
        ST_SCAN: begin
          if (r_cnt != '0) begin
            w_cnt_next = r_cnt - CW'(1);
          end else if (r_code == 3'd7) begin
            w_state_next = ST_IDLE;
            w_y_next     = 8'hFF;
            w_code_next  = 3'd0;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
          end else begin
            // Move the single low bit up one line with no idle gap.
            w_cnt_next  = CW'(DWELL - 1);
            w_y_next    = {r_y[6:0], 1'b1};
            w_code_next = r_code + 3'd1;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
          w_y_next     = 8'hFF;
          w_code_next  = 3'd0;
          w_busy_next  = 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE) & ~bus.E;
  assign bus.Y         = r_y;
  assign bus.code_o    = r_code;
  assign bus.busy      = r_busy;
  assign bus.scan_done = r_done;

endmodule

// File: tb/tb_decoder3_8_scan.sv
// Randomised and directed bench for decoder3_8_scan against a time-based model
// that derives the low line from elapsed cycles since the operation began.
module tb_decoder3_8_scan;
  localparam int HOLD  = 4;
  localparam int DWELL = 4;
  localparam logic [7:0] SCAN_Y [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                                        8'hEF, 8'hDF, 8'hBF, 8'h7F};

  logic clk = 1'b0;
  logic rst;
  decoder3_8_scan_if bus();

  decoder3_8_scan #(.HOLD(HOLD), .DWELL(DWELL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode 0 idle, 1 direct, 2 scan; m_t counts cycles since the start edge.
  int   m_mode = 0;
  int   m_t    = 0;
  int   m_a    = 0;
  logic m_done = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, e, v, input logic [2:0] a, input logic s);
    m_done = 1'b0;
    if (r || e) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (v) begin
        m_mode = 1; m_a = int'(a); m_t = 0;
      end else if (s) begin
        m_mode = 2; m_t = 0;
      end
    end else begin
      m_t++;
      if (m_mode == 1 && m_t == HOLD) m_mode = 0;
      if (m_mode == 2 && m_t == 8 * DWELL) begin
        m_mode = 0; m_done = 1'b1;
      end
    end
  endtask

  task automatic compare();
    logic [7:0] one;
    logic [7:0] ey;
    int         ec;
    one = 8'd1;
    ec  = 0;
    ey  = 8'hFF;
    if (m_mode == 1) begin ec = m_a; ey = ~(one << m_a); end
    if (m_mode == 2) begin ec = m_t / DWELL; ey = ~(one << ec); end
    chk("Y", bus.Y, ey);
    chk("code_o", {5'd0, bus.code_o}, 8'(ec));
    chk("busy", {7'd0, bus.busy}, {7'd0, (m_mode != 0)});
    chk("scan_done", {7'd0, bus.scan_done}, {7'd0, m_done});
    chk("in_ready", {7'd0, bus.in_ready}, {7'd0, (m_mode == 0) && !bus.E});
    chk("onehot_low", {7'd0, ($countones(~bus.Y) <= 1)}, 8'd1);
    if (bus.Y == 8'hFF)
      chk("code_idle", {5'd0, bus.code_o}, 8'd0);
    else
      chk("code_vs_Y", bus.Y, ~(one << bus.code_o));
  endtask

  task automatic step(input logic r, e, v, input logic [2:0] a, input logic s);
    rst            = r;
    bus.E          = e;
    bus.in_valid   = v;
    bus.A          = a;
    bus.scan_start = s;
    @(posedge clk);
    model_update(r, e, v, a, s);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'($urandom), 1'b0);
  endtask

  initial begin
    logic [7:0] lit;
    logic [7:0] one;
    one = 8'd1;

    // Reset with random side inputs
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b0, 1'($urandom), 3'($urandom), 1'($urandom));
    chk("rst_Y", bus.Y, 8'hFF);
    chk("rst_in_ready", {7'd0, bus.in_ready}, 8'd1);
    $display("reset done Y=%h busy=%0d", bus.Y, bus.busy);

    // Direct decode of every code, back to back
    for (int a = 0; a < 8; a++) begin
      step(1'b0, 1'b0, 1'b1, 3'(a), 1'b0);
      lit = ~(one << a);
      chk("direct_first", bus.Y, lit);
      idle(HOLD - 1);
      chk("direct_last", bus.Y, lit);
      idle(1);
      chk("direct_release", bus.Y, 8'hFF);
      $display("direct A=%0d Y=%h", a, lit);
    end
    step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    chk("A0_FE", bus.Y, 8'hFE);
    idle(HOLD);
    step(1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
    chk("A7_7F", bus.Y, 8'h7F);
    idle(HOLD);

    // Full scan against a literal table
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    chk("scan_line", bus.Y, SCAN_Y[0]);
    for (int k = 1; k < 8 * DWELL; k++) begin
      idle(1);
      chk("scan_line", bus.Y, SCAN_Y[k / DWELL]);
    end
    idle(1);
    chk("scan_end_Y", bus.Y, 8'hFF);
    chk("scan_done_pulse", {7'd0, bus.scan_done}, 8'd1);
    idle(1);
    chk("scan_done_clear", {7'd0, bus.scan_done}, 8'd0);
    $display("scan complete");

    // Contention: direct wins, requests during HOLD are ignored
    step(1'b0, 1'b0, 1'b1, 3'd5, 1'b1);
    chk("contention_DF", bus.Y, 8'hDF);
    for (int i = 0; i < HOLD; i++)
      step(1'b0, 1'b0, 1'($urandom), 3'($urandom), 1'($urandom));
    idle(1);
    chk("no_scan_after", bus.Y, 8'hFF);
    $display("contention A=5 with scan_start");

    // Abort by E then by rst at cycle 10 of a scan
    for (int m = 0; m < 2; m++) begin
      step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
      idle(9);
      if (m == 0) step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
      else        step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
      chk("abort_Y", bus.Y, 8'hFF);
      chk("abort_busy", {7'd0, bus.busy}, 8'd0);
      if (m == 0) begin
        step(1'b0, 1'b1, 1'b1, 3'd3, 1'b1);
        chk("abort_in_ready", {7'd0, bus.in_ready}, 8'd0);
      end
      idle(8 * DWELL);
      $display("abort by %s at scan cycle 10", (m == 0) ? "E" : "rst");
    end

    // Random traffic
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 9) == 0), 3'($urandom), ($urandom_range(0, 14) == 0));
    $display("random traffic 1500 cycles");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
